// File: rtl/reservation_station_pkg.sv
// Shared constants, entry types and the CDB snoop helper for the reservation station.
// The RS_PERF_CNT_EN build option is handled in the top-level file.
package reservation_station_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int ROB_TAG_WIDTH       = 5;
    localparam int INSIDE_OPCODE_WIDTH = 6;

    typedef logic [ROB_TAG_WIDTH-1:0]       rob_tag_t;
    typedef logic [DATA_WIDTH-1:0]          data_t;
    typedef logic [INSIDE_OPCODE_WIDTH-1:0] op_t;

    localparam rob_tag_t ZERO_TAG_ROB = '0;
    localparam data_t    ZERO_DATA    = '0;
    localparam logic     TRUE         = 1'b1;
    localparam logic     FALSE        = 1'b0;

    typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5,
        OP_SLL  = 6'd6,
        OP_SRL  = 6'd7,
        OP_SRA  = 6'd8,
        OP_SLT  = 6'd9,
        OP_SLTU = 6'd10
    } inside_op_e;

    localparam op_t NOP = OP_NOP;

    typedef struct packed {
        rob_tag_t tag;
        data_t    value;
    } operand_t;

    typedef struct packed {
        op_t      op;
        operand_t src1;
        operand_t src2;
        data_t    imm;
        data_t    pc;
        rob_tag_t rob_tag;
    } rs_entry_t;

    // A pending operand picks up the value from whichever bus carries its producer tag.
    function automatic operand_t snoop(rob_tag_t tag, data_t value,
                                       rob_tag_t alu_tag, data_t alu_value,
                                       rob_tag_t lsb_tag, data_t lsb_value);
        operand_t res;
        res.tag   = tag;
        res.value = value;
        if (tag != ZERO_TAG_ROB) begin
            if (tag == alu_tag) begin
                res.tag   = ZERO_TAG_ROB;
                res.value = alu_value;
            end else if (tag == lsb_tag) begin
                res.tag   = ZERO_TAG_ROB;
                res.value = lsb_value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop, flush and issue signals of the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    rob_tag_t in_decode_rob_tag;
    op_t      in_decode_op;
    data_t    in_decode_value1;
    data_t    in_decode_value2;
    rob_tag_t in_decode_tag1;
    rob_tag_t in_decode_tag2;
    data_t    in_decode_imm;
    data_t    in_decode_pc;
    logic     out_decode_full;
    rob_tag_t in_alu_cdb_tag;
    data_t    in_alu_cdb_value;
    rob_tag_t in_lsb_cdb_tag;
    data_t    in_lsb_cdb_value;
    logic     in_rob_flush;
    rob_tag_t out_alu_rob_tag;
    op_t      out_alu_op;
    data_t    out_alu_value1;
    data_t    out_alu_value2;
    data_t    out_alu_imm;
    data_t    out_alu_pc;

    modport slave (
        input  in_decode_rob_tag, in_decode_op, in_decode_value1, in_decode_value2,
               in_decode_tag1, in_decode_tag2, in_decode_imm, in_decode_pc,
               in_alu_cdb_tag, in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value,
               in_rob_flush,
        output out_decode_full, out_alu_rob_tag, out_alu_op, out_alu_value1,
               out_alu_value2, out_alu_imm, out_alu_pc
    );

    modport master (
        output in_decode_rob_tag, in_decode_op, in_decode_value1, in_decode_value2,
               in_decode_tag1, in_decode_tag2, in_decode_imm, in_decode_pc,
               in_alu_cdb_tag, in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value,
               in_rob_flush,
        input  out_decode_full, out_alu_rob_tag, out_alu_op, out_alu_value1,
               out_alu_value2, out_alu_imm, out_alu_pc
    );
endinterface

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index priority encoder returning the first set request bit.
module rs_select #(
    parameter  int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);
    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until operands arrive, issues one per cycle.
// Define RS_PERF_CNT_EN to add the issue and full-cycle performance counters.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    reservation_station_if.slave bus
`ifdef RS_PERF_CNT_EN
    ,
    output logic [31:0] out_perf_issue_cnt,
    output logic [31:0] out_perf_full_cycles
`endif
);
    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t [RS_SIZE-1:0] entry_vec;
    logic [RS_SIZE-1:0]      busy_vec;
    logic [RS_SIZE-1:0]      free_vec;
    logic [RS_SIZE-1:0]      ready_vec;
    logic [IDX_W-1:0]        free_idx;
    logic [IDX_W-1:0]        issue_idx;
    logic                    free_found;
    logic                    issue_found;
    logic                    dispatch_en;
    logic                    decode_full;
    logic [IDX_W:0]          free_cnt;
    rs_entry_t               dispatch_entry;

    rob_tag_t out_tag_reg;
    op_t      out_op_reg;
    data_t    out_v1_reg;
    data_t    out_v2_reg;
    data_t    out_imm_reg;
    data_t    out_pc_reg;

    assign free_vec = ~busy_vec;

    rs_select #(.N(RS_SIZE)) u_free_sel  (.req(free_vec),  .idx(free_idx),  .found(free_found));
    rs_select #(.N(RS_SIZE)) u_issue_sel (.req(ready_vec), .idx(issue_idx), .found(issue_found));

    // Incoming operands are bypassed so a same-cycle broadcast is not missed.
    always_comb begin
        dispatch_entry.op      = bus.in_decode_op;
        dispatch_entry.src1    = snoop(bus.in_decode_tag1, bus.in_decode_value1,
                                       bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                                       bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
        dispatch_entry.src2    = snoop(bus.in_decode_tag2, bus.in_decode_value2,
                                       bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                                       bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
        dispatch_entry.imm     = bus.in_decode_imm;
        dispatch_entry.pc      = bus.in_decode_pc;
        dispatch_entry.rob_tag = bus.in_decode_rob_tag;
    end

    // No free slot means the dispatch is dropped.
    assign dispatch_en = (bus.in_decode_rob_tag != ZERO_TAG_ROB) && free_found;

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        logic      busy_reg;
        rs_entry_t entry_reg;
        rs_entry_t woken;

        always_comb begin
            woken      = entry_reg;
            woken.src1 = snoop(entry_reg.src1.tag, entry_reg.src1.value,
                               bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                               bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
            woken.src2 = snoop(entry_reg.src2.tag, entry_reg.src2.value,
                               bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                               bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                busy_reg <= FALSE;
            end else if (rdy) begin
                if (bus.in_rob_flush) begin
                    busy_reg <= FALSE;
                end else if (busy_reg) begin
                    if (issue_found && issue_idx == IDX_W'(gi)) begin
                        busy_reg <= FALSE;
                    end
                    entry_reg <= woken;
                end else if (dispatch_en && free_idx == IDX_W'(gi)) begin
                    busy_reg  <= TRUE;
                    entry_reg <= dispatch_entry;
                end
            end
        end

        assign busy_vec[gi]  = busy_reg;
        assign entry_vec[gi] = entry_reg;
        assign ready_vec[gi] = busy_reg && (entry_reg.src1.tag == ZERO_TAG_ROB)
                                        && (entry_reg.src2.tag == ZERO_TAG_ROB);
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_cnt = free_cnt + {{IDX_W{1'b0}}, free_vec[i]};
        end
    end

    // One spare slot covers the dispatch already in flight when the stall is seen.
    assign decode_full = (free_cnt <= (IDX_W + 1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_tag_reg <= ZERO_TAG_ROB;
            out_op_reg  <= NOP;
            out_v1_reg  <= ZERO_DATA;
            out_v2_reg  <= ZERO_DATA;
            out_imm_reg <= ZERO_DATA;
            out_pc_reg  <= ZERO_DATA;
        end else if (rdy) begin
            if (bus.in_rob_flush || !issue_found) begin
                out_tag_reg <= ZERO_TAG_ROB;
            end else begin
                out_tag_reg <= entry_vec[issue_idx].rob_tag;
                out_op_reg  <= entry_vec[issue_idx].op;
                out_v1_reg  <= entry_vec[issue_idx].src1.value;
                out_v2_reg  <= entry_vec[issue_idx].src2.value;
                out_imm_reg <= entry_vec[issue_idx].imm;
                out_pc_reg  <= entry_vec[issue_idx].pc;
            end
        end
    end

    assign bus.out_decode_full = decode_full;
    assign bus.out_alu_rob_tag = out_tag_reg;
    assign bus.out_alu_op      = out_op_reg;
    assign bus.out_alu_value1  = out_v1_reg;
    assign bus.out_alu_value2  = out_v2_reg;
    assign bus.out_alu_imm     = out_imm_reg;
    assign bus.out_alu_pc      = out_pc_reg;

`ifdef RS_PERF_CNT_EN
    logic [31:0] perf_issue_reg;
    logic [31:0] perf_full_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_reg <= '0;
            perf_full_reg  <= '0;
        end else if (rdy) begin
            if (!bus.in_rob_flush && issue_found) begin
                perf_issue_reg <= perf_issue_reg + 32'd1;
            end
            if (decode_full) begin
                perf_full_reg <= perf_full_reg + 32'd1;
            end
        end
    end

    assign out_perf_issue_cnt   = perf_issue_reg;
    assign out_perf_full_cycles = perf_full_reg;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-level model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int RS_SIZE = 16;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    reservation_station_if rs_bus();

`ifdef RS_PERF_CNT_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_full;
`endif

    reservation_station #(.RS_SIZE(RS_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (rs_bus)
`ifdef RS_PERF_CNT_EN
        ,
        .out_perf_issue_cnt   (perf_issue),
        .out_perf_full_cycles (perf_full)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one record per slot, updated once per clock edge.
    typedef struct {
        bit       busy;
        op_t      op;
        rob_tag_t t1;
        rob_tag_t t2;
        data_t    v1;
        data_t    v2;
        data_t    imm;
        data_t    pc;
        rob_tag_t rob;
    } m_entry_t;

    m_entry_t    m_rs [RS_SIZE];
    rob_tag_t    e_tag;
    op_t         e_op;
    data_t       e_v1, e_v2, e_imm, e_pc;
    int unsigned e_issue_cnt, e_full_cnt;

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) if (!m_rs[i].busy) n++;
        return n;
    endfunction

    // Resolve an operand against whatever the two buses show this cycle.
    task automatic resolve(input rob_tag_t t, input data_t v, output rob_tag_t to, output data_t vo);
        to = t;
        vo = v;
        if (t != ZERO_TAG_ROB && t == rs_bus.in_alu_cdb_tag) begin
            to = ZERO_TAG_ROB;
            vo = rs_bus.in_alu_cdb_value;
        end else if (t != ZERO_TAG_ROB && t == rs_bus.in_lsb_cdb_tag) begin
            to = ZERO_TAG_ROB;
            vo = rs_bus.in_lsb_cdb_value;
        end
    endtask

    always @(posedge clk) begin : model_p
        m_entry_t old [RS_SIZE];
        int iss;
        int fr;
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) m_rs[i].busy = 1'b0;
            e_tag = ZERO_TAG_ROB; e_op = NOP;
            e_v1 = ZERO_DATA; e_v2 = ZERO_DATA; e_imm = ZERO_DATA; e_pc = ZERO_DATA;
            e_issue_cnt = 0; e_full_cnt = 0;
        end else if (rdy) begin
            old = m_rs;
            if (m_free() <= 1) e_full_cnt++;
            if (rs_bus.in_rob_flush) begin
                for (int i = 0; i < RS_SIZE; i++) m_rs[i].busy = 1'b0;
                e_tag = ZERO_TAG_ROB;
            end else begin
                iss = -1;
                fr  = -1;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (iss < 0 && old[i].busy && old[i].t1 == ZERO_TAG_ROB && old[i].t2 == ZERO_TAG_ROB) iss = i;
                    if (fr < 0 && !old[i].busy) fr = i;
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (old[i].busy) begin
                        resolve(old[i].t1, old[i].v1, m_rs[i].t1, m_rs[i].v1);
                        resolve(old[i].t2, old[i].v2, m_rs[i].t2, m_rs[i].v2);
                    end
                end
                if (iss >= 0) begin
                    e_tag = old[iss].rob; e_op = old[iss].op;
                    e_v1 = old[iss].v1; e_v2 = old[iss].v2;
                    e_imm = old[iss].imm; e_pc = old[iss].pc;
                    m_rs[iss].busy = 1'b0;
                    e_issue_cnt++;
                    $display("issue rob=%0d op=%0d v1=0x%0h v2=0x%0h t=%0t", e_tag, e_op, e_v1, e_v2, $time);
                end else begin
                    e_tag = ZERO_TAG_ROB;
                end
                if (rs_bus.in_decode_rob_tag != ZERO_TAG_ROB && fr >= 0) begin
                    m_rs[fr].busy = 1'b1;
                    m_rs[fr].op   = rs_bus.in_decode_op;
                    m_rs[fr].imm  = rs_bus.in_decode_imm;
                    m_rs[fr].pc   = rs_bus.in_decode_pc;
                    m_rs[fr].rob  = rs_bus.in_decode_rob_tag;
                    resolve(rs_bus.in_decode_tag1, rs_bus.in_decode_value1, m_rs[fr].t1, m_rs[fr].v1);
                    resolve(rs_bus.in_decode_tag2, rs_bus.in_decode_value2, m_rs[fr].t2, m_rs[fr].v2);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("full",   64'(rs_bus.out_decode_full), 64'(m_free() <= 1));
            chk("tag",    64'(rs_bus.out_alu_rob_tag), 64'(e_tag));
            chk("op",     64'(rs_bus.out_alu_op),      64'(e_op));
            chk("value1", 64'(rs_bus.out_alu_value1),  64'(e_v1));
            chk("value2", 64'(rs_bus.out_alu_value2),  64'(e_v2));
            chk("imm",    64'(rs_bus.out_alu_imm),     64'(e_imm));
            chk("pc",     64'(rs_bus.out_alu_pc),      64'(e_pc));
`ifdef RS_PERF_CNT_EN
            chk("perf_issue", 64'(perf_issue), 64'(e_issue_cnt));
            chk("perf_full",  64'(perf_full),  64'(e_full_cnt));
`endif
        end
    end

    task automatic idle();
        rs_bus.in_decode_rob_tag = ZERO_TAG_ROB;
        rs_bus.in_decode_op      = NOP;
        rs_bus.in_decode_value1  = ZERO_DATA;
        rs_bus.in_decode_value2  = ZERO_DATA;
        rs_bus.in_decode_tag1    = ZERO_TAG_ROB;
        rs_bus.in_decode_tag2    = ZERO_TAG_ROB;
        rs_bus.in_decode_imm     = ZERO_DATA;
        rs_bus.in_decode_pc      = ZERO_DATA;
        rs_bus.in_alu_cdb_tag    = ZERO_TAG_ROB;
        rs_bus.in_alu_cdb_value  = ZERO_DATA;
        rs_bus.in_lsb_cdb_tag    = ZERO_TAG_ROB;
        rs_bus.in_lsb_cdb_value  = ZERO_DATA;
        rs_bus.in_rob_flush      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic disp(input rob_tag_t rob, input op_t op, input data_t v1, input rob_tag_t t1,
                        input data_t v2, input rob_tag_t t2);
        rs_bus.in_decode_rob_tag = rob;
        rs_bus.in_decode_op      = op;
        rs_bus.in_decode_value1  = v1;
        rs_bus.in_decode_tag1    = t1;
        rs_bus.in_decode_value2  = v2;
        rs_bus.in_decode_tag2    = t2;
        rs_bus.in_decode_imm     = {27'd0, rob} << 4;
        rs_bus.in_decode_pc      = 32'h1000 + ({27'd0, rob} << 2);
    endtask

    function automatic rob_tag_t rnd_src();
        if ($urandom_range(0, 2) == 0) return ZERO_TAG_ROB;
        return rob_tag_t'($urandom_range(1, 7));
    endfunction

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        checking = 1'b1;
        tick();
        chk("reset_tag",  64'(rs_bus.out_alu_rob_tag), 64'd0);
        chk("reset_full", 64'(rs_bus.out_decode_full), 64'd0);
        chk("reset_op",   64'(rs_bus.out_alu_op),      64'(OP_NOP));

        // Ready-at-dispatch ADD issues one edge later.
        disp(5'd3, OP_ADD, 32'd5, 5'd0, 32'd7, 5'd0);
        tick();
        idle();
        chk("add_not_same_cycle", 64'(rs_bus.out_alu_rob_tag), 64'd0);
        tick();
        chk("add_tag", 64'(rs_bus.out_alu_rob_tag), 64'd3);
        chk("add_v1",  64'(rs_bus.out_alu_value1),  64'd5);
        chk("add_v2",  64'(rs_bus.out_alu_value2),  64'd7);
        chk("add_op",  64'(rs_bus.out_alu_op),      64'(OP_ADD));
        tick();
        chk("add_freed", 64'(rs_bus.out_alu_rob_tag), 64'd0);

        // SUB waits for ALU CDB tag 2.
        disp(5'd4, OP_SUB, 32'h55, 5'd2, 32'd9, 5'd0);
        tick();
        idle();
        tick();
        chk("sub_blocked", 64'(rs_bus.out_alu_rob_tag), 64'd0);
        rs_bus.in_alu_cdb_tag   = 5'd2;
        rs_bus.in_alu_cdb_value = 32'h100;
        tick();
        idle();
        chk("sub_wake_edge", 64'(rs_bus.out_alu_rob_tag), 64'd0);
        tick();
        chk("sub_tag", 64'(rs_bus.out_alu_rob_tag), 64'd4);
        chk("sub_v1",  64'(rs_bus.out_alu_value1),  64'h100);

        // Same-cycle LSB broadcast bypassed into the dispatched operand.
        disp(5'd5, OP_AND, 32'd1, 5'd0, 32'd0, 5'd6);
        rs_bus.in_lsb_cdb_tag   = 5'd6;
        rs_bus.in_lsb_cdb_value = 32'hDEAD;
        tick();
        idle();
        tick();
        chk("bypass_tag", 64'(rs_bus.out_alu_rob_tag), 64'd5);
        chk("bypass_v2",  64'(rs_bus.out_alu_value2),  64'hDEAD);

        // Fill RS_SIZE-1 blocked entries.
        for (int i = 0; i < RS_SIZE - 1; i++) begin
            disp(rob_tag_t'(16 + i), OP_OR, data_t'(i), rob_tag_t'(i + 1), data_t'(i), 5'd0);
            tick();
            if (i == RS_SIZE - 3) chk("full_at_two_free", 64'(rs_bus.out_decode_full), 64'd0);
        end
        idle();
        chk("full_at_one_free", 64'(rs_bus.out_decode_full), 64'd1);
        rs_bus.in_alu_cdb_tag   = 5'd1;
        rs_bus.in_alu_cdb_value = 32'h77;
        tick();
        idle();
        tick();
        chk("fill_issue_tag", 64'(rs_bus.out_alu_rob_tag), 64'd16);
        chk("fill_issue_v1",  64'(rs_bus.out_alu_value1),  64'h77);
        chk("full_released",  64'(rs_bus.out_decode_full), 64'd0);
        rs_bus.in_rob_flush = 1'b1;
        tick();
        idle();

        // Six blocked entries, then flush together with an ignored dispatch.
        for (int i = 0; i < 6; i++) begin
            disp(rob_tag_t'(i + 1), OP_XOR, 32'd0, rob_tag_t'(20 + i), 32'd0, 5'd0);
            tick();
        end
        disp(5'd8, OP_ADD, 32'd1, 5'd0, 32'd2, 5'd0);
        rs_bus.in_rob_flush = 1'b1;
        tick();
        idle();
        chk("flush_tag",  64'(rs_bus.out_alu_rob_tag), 64'd0);
        chk("flush_full", 64'(rs_bus.out_decode_full), 64'd0);
        rs_bus.in_alu_cdb_tag = 5'd20;
        rs_bus.in_lsb_cdb_tag = 5'd21;
        tick();
        idle();
        tick();
        chk("flush_no_issue_a", 64'(rs_bus.out_alu_rob_tag), 64'd0);
        tick();
        chk("flush_no_issue_b", 64'(rs_bus.out_alu_rob_tag), 64'd0);
        disp(5'd9, OP_ADD, 32'd11, 5'd0, 32'd12, 5'd0);
        tick();
        idle();
        tick();
        chk("post_flush_tag", 64'(rs_bus.out_alu_rob_tag), 64'd9);
        chk("post_flush_v2",  64'(rs_bus.out_alu_value2),  64'd12);
`ifdef RS_PERF_CNT_EN
        chk("perf_issue_literal", 64'(perf_issue), 64'd5);
        chk("perf_full_literal",  64'(perf_full),  64'd2);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 499) == 0);
            rdy = rst ? 1'b1 : ($urandom_range(0, 9) != 0);
            rs_bus.in_rob_flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) < 60) begin
                disp(rob_tag_t'($urandom_range(1, 31)), op_t'($urandom_range(1, 10)),
                     $urandom(), rnd_src(), $urandom(), rnd_src());
            end
            if ($urandom_range(0, 1) == 1) begin
                rs_bus.in_alu_cdb_tag   = rob_tag_t'($urandom_range(1, 7));
                rs_bus.in_alu_cdb_value = $urandom();
            end
            if ($urandom_range(0, 1) == 1) begin
                rs_bus.in_lsb_cdb_tag   = rob_tag_t'($urandom_range(1, 7));
                rs_bus.in_lsb_cdb_value = $urandom();
                if (rs_bus.in_lsb_cdb_tag == rs_bus.in_alu_cdb_tag) rs_bus.in_lsb_cdb_tag = ZERO_TAG_ROB;
            end
            tick();
        end
        idle();
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
